load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; the data and address width is fixed at 32.
REQ-002 SHALL expose these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  aligned, extended load data.
- resp_err  out  1  misalignment flag; tied 0 without LSU_MISALIGN_TRAP_EN.
- mem_write  out  1  word write strobe to data memory.
- mem_address  out  32  word-aligned address to data memory.
- mem_write_data  out  32  merged word to data memory.
- mem_read_data  in  32  combinational read word from data memory.

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-004 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-005 SHALL latch addr, size, unsigned, write and wdata on acceptance; later changes to the req_* inputs SHALL be ignored until DONE.
REQ-006 Transitions SHALL be:
- load: IDLE->READ->DONE.
- word store: IDLE->WRITE->DONE.
- byte/half store: IDLE->READ->WRITE->DONE.
- DONE->IDLE, always.
REQ-007 Latency from the acceptance edge to the resp_valid cycle SHALL be 2 cycles for a load, 2 for a word store and 3 for a sub-word store.
REQ-008 mem_address SHALL equal {latched_addr[31:2],2'b00} in every state, and 0 after reset until the first acceptance.
REQ-009 mem_write SHALL be 1 only in WRITE and only while reset=0.
REQ-010 READ SHALL capture mem_read_data into an internal word register at the end of the cycle.
REQ-011 Merge rules:
- byte store replaces lane addr[1:0] (lane 0 = bits 7:0) with wdata[7:0].
- half store replaces the lane pair selected by addr[1] with wdata[15:0].
- word store writes wdata unchanged.
- bytes outside the replaced lanes keep their captured values.
REQ-012 Load extraction SHALL use the same lane selection; the result SHALL be sign-extended from bit 7 or 15 when req_unsigned=0 and zero-extended when it is 1.
REQ-013 resp_rdata SHALL be valid in DONE and hold its value until the next DONE; for stores it SHALL be 0.
REQ-014 resp_valid SHALL be 1 exactly in DONE; there is no response backpressure.
REQ-015 A request presented in DONE SHALL NOT be accepted; it may be accepted in the following IDLE cycle.

Reset
REQ-016 The next edge with reset=1 SHALL set the state to IDLE and clear req_ready's blocking state, resp_valid, resp_rdata, resp_err, the latched address and the captured word to 0.
REQ-017 Reset asserted during WRITE SHALL suppress that write, and the aborted request SHALL produce no response.

Configuration
REQ-018 With LSU_MISALIGN_TRAP_EN defined:
- misaligned means a half with addr[0]=1, or a word with addr[1:0]!=0.
- a misaligned request SHALL go IDLE->DONE and never assert mem_write.
- DONE SHALL show resp_err=1 and resp_rdata=0.
REQ-019 Without LSU_MISALIGN_TRAP_EN:
- resp_err SHALL be constant 0.
- a half access SHALL ignore addr[0]; a word access SHALL ignore addr[1:0].

Structure
REQ-020 Package lsu_pkg SHALL hold the size encoding (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-021 The combinational lane extract/merge SHALL be the sub-module lsu_lane_align; the FSM and registers stay in load_store_unit.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Word 0x11223344 at addr 0x10; byte store 0xAA to 0x12 -> word becomes 0x11AA3344 after 3 cycles, with mem_write high for exactly 1 cycle.
- Word 0x0000F080 at 0x20: signed byte load from 0x20 -> 0xFFFFFF80; unsigned half load from 0x20 -> 0x0000F080.
- Word store 0xDEADBEEF to 0x3C, then word load from 0x3C -> resp_rdata=0xDEADBEEF, 2 cycles after acceptance.
- Back-to-back requests with req_valid held high -> second acceptance occurs in the IDLE cycle after DONE, never in DONE.
- Reset pulsed during WRITE of a store to 0x40 -> memory at 0x40 unchanged, no resp_valid, state IDLE.
- Half load at 0x41: with macro -> resp_err=1, rdata=0, no memory write; without macro -> data from the lane at 0x40.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM state type
// and the misalignment predicate used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } lsu_state_t;

    // Size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF)
            mis = lane[0];
        else if (size[1])
            mis = (lane != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a memory word,
// and merges right-aligned store data into a previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_base_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rd_word[{i_lane, 3'b000} +: 8];
        w_half   = i_rd_word[{i_lane[1], 4'b0000} +: 16];
        o_rdata  = i_rd_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_rdata  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merged = i_base_word;
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                // addr[0] is ignored: the half lane is chosen by addr[1] alone.
                o_rdata  = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merged = i_base_word;
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_rdata  = i_rd_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a core request port to a word-wide data memory with
// sub-word read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_write;
    logic        r_err;

    logic        w_accept;
    logic        w_trap;
    logic        w_word_store;
    logic [31:0] w_lane_rdata;
    logic [31:0] w_merged;

    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid && req_ready;
    assign w_word_store = req_write && req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .i_rd_word   (mem_read_data),
        .i_base_word (r_word),
        .i_wdata     (r_wdata),
        .i_lane      (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .o_rdata     (w_lane_rdata),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_word  <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        if (w_trap) begin
                            r_state <= DONE;
                            r_rdata <= 32'h0;
                            r_err   <= 1'b1;
                        end else if (w_word_store) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    r_word <= mem_read_data;
                    if (r_write) begin
                        r_state <= WRITE;
                    end else begin
                        r_state <= DONE;
                        r_rdata <= w_lane_rdata;
                        r_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state <= DONE;
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request attributes only steer the datapath; the FSM reset makes them don't-care.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
        end
    end

    assign resp_valid     = (r_state == DONE);
    assign resp_rdata     = r_rdata;
    assign resp_err       = r_err;
    assign mem_write      = (r_state == WRITE) && !reset;
    assign mem_address    = {r_addr[31:2], 2'b00};
    assign mem_write_data = w_merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-schedule reference model and a
// small word memory; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        case (idx)
            4:       return 32'h1122_3344;
            8:       return 32'h0000_F080;
            16:      return 32'h1234_8765;
            default: return 32'h0;
        endcase
    endfunction

    // Data memory seen by the DUT: 64 words at byte addresses 0x00..0xFF.
    logic [31:0] mem [0:63];
    logic        mem_loaded = 1'b0;

    assign mem_read_data = (mem_address[31:8] == 24'h0) ? mem[mem_address[7:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[7:2]] <= mem_write_data;
        end
    end

    // Reference model: byte-lane arithmetic on a private memory copy.
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return (sz == 2'b11) && (a == 32'hFFFF_FFFF);
`endif
    endfunction

    logic [31:0] mm [0:63];
    logic        mm_loaded = 1'b0;
    int          free_from = 0;
    int          done_cyc = -1;
    int          wr_cyc = -1;
    int          wr_idx = 0;
    logic [31:0] wr_word = 32'h0;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_err = 1'b0;
    logic [31:0] last_rd = 32'h0;
    logic        last_err = 1'b0;
    logic [31:0] lat_addr = 32'h0;

    always @(negedge clk) begin
        if (!mm_loaded) begin
            for (int i = 0; i < 64; i++) mm[i] = init_word(i);
            mm_loaded = 1'b1;
        end
        chk("req_ready", {31'h0, req_ready}, {31'h0, cyc >= free_from});
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, cyc == done_cyc});
        chk("mem_write", {31'h0, mem_write}, {31'h0, (cyc == wr_cyc) && !reset});
        chk("mem_address", mem_address, {lat_addr[31:2], 2'b00});
        if (cyc == done_cyc) begin
            last_rd  = exp_rd;
            last_err = exp_err;
        end
        chk("resp_rdata", resp_rdata, last_rd);
        chk("resp_err", {31'h0, resp_err}, {31'h0, last_err});
        if (cyc == wr_cyc && !reset) begin
            chk("mem_write_data", mem_write_data, wr_word);
            mm[wr_idx] = wr_word;
        end
        if (reset) begin
            free_from = cyc + 1;
            done_cyc  = -1;
            wr_cyc    = -1;
            lat_addr  = 32'h0;
            last_rd   = 32'h0;
            last_err  = 1'b0;
        end else if (req_valid && cyc >= free_from) begin
            lat_addr = req_addr;
            wr_idx   = int'(req_addr[7:2]);
            exp_err  = 1'b0;
            exp_rd   = 32'h0;
            wr_cyc   = -1;
            if (m_misaligned(req_size, req_addr)) begin
                done_cyc = cyc + 1;
                exp_err  = 1'b1;
            end else if (!req_write) begin
                done_cyc = cyc + 2;
                exp_rd   = m_load(mm[wr_idx], req_size, req_unsigned, req_addr);
            end else if (req_size[1]) begin
                wr_cyc   = cyc + 1;
                done_cyc = cyc + 2;
                wr_word  = req_wdata;
            end else begin
                wr_cyc   = cyc + 2;
                done_cyc = cyc + 3;
                wr_word  = m_store(mm[wr_idx], req_size, req_addr, req_wdata);
            end
            free_from = done_cyc + 1;
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output int acc);
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int dc, output logic [31:0] rd, output logic er, output int nwr);
        dc = -1; rd = 32'h0; er = 1'b0; nwr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_write) nwr++;
            if (resp_valid) begin
                dc = cyc;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        if (dc < 0) chk("resp_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int nwr);
        int acc, dc;
        issue(w, sz, uns, a, wd, acc);
        req_valid = 1'b0;
        wait_resp(dc, rd, er, nwr);
        lat = dc - acc;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, nwr, acc1, acc2, dc2, nresp;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);

        // Byte store into lane 2 of 0x11223344.
        xact(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, rd, er, lat, nwr);
        chk("sb_latency", lat, 3);
        chk("sb_write_cycles", nwr, 1);
        chk("sb_mem_word", mem[4], 32'h11AA_3344);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr);
        chk("lw_0x10", rd, 32'h11AA_3344);

        // Sign/zero extension from 0x0000F080.
        xact(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, er, lat, nwr);
        chk("lb_0x20", rd, 32'hFFFF_FF80);
        chk("lb_latency", lat, 2);
        xact(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat, nwr);
        chk("lhu_0x20", rd, 32'h0000_F080);
        xact(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er, lat, nwr);
        chk("lh_0x20", rd, 32'hFFFF_F080);
        xact(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat, nwr);
        chk("lbu_0x21", rd, 32'h0000_00F0);

        // Word store then load back; upper-half store; size 11 as word.
        xact(1'b1, 2'b10, 1'b0, 32'h3C, 32'hDEAD_BEEF, rd, er, lat, nwr);
        chk("sw_latency", lat, 2);
        chk("sw_write_cycles", nwr, 1);
        chk("sw_rdata_zero", rd, 32'h0);
        xact(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er, lat, nwr);
        chk("lw_0x3c", rd, 32'hDEAD_BEEF);
        chk("lw_latency", lat, 2);
        xact(1'b1, 2'b01, 1'b0, 32'h3E, 32'h1234_BEEF, rd, er, lat, nwr);
        chk("sh_latency", lat, 3);
        xact(1'b0, 2'b00, 1'b1, 32'h3F, 32'h0, rd, er, lat, nwr);
        chk("lbu_0x3f", rd, 32'h0000_00BE);
        xact(1'b0, 2'b11, 1'b0, 32'h3C, 32'h0, rd, er, lat, nwr);
        chk("lsz11_0x3c", rd, 32'hBEEF_BEEF);

        // Back-to-back with req_valid held; fields change right after acceptance.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, acc1);
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, acc2);
        req_valid = 1'b0;
        chk("b2b_accept_gap", acc2 - acc1, 3);
        wait_resp(dc2, rd, er, nwr);
        chk("b2b_second_rdata", rd, 32'hFFFF_FF80);
        chk("b2b_second_latency", dc2 - acc2, 2);

        // Reset during WRITE aborts the store and its response.
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, acc1);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        nresp = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        @(posedge clk);
        #1;
        chk("abort_no_resp", nresp, 0);
        chk("abort_mem_0x40", mem[16], 32'h1234_8765);

        // Misaligned half load and word store.
        xact(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, rd, er, lat, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_0x41_rdata", rd, 32'h0);
        chk("lh_0x41_err", {31'h0, er}, 32'h1);
        chk("lh_0x41_latency", lat, 1);
`else
        chk("lh_0x41_rdata", rd, 32'hFFFF_8765);
        chk("lh_0x41_err", {31'h0, er}, 32'h0);
        chk("lh_0x41_latency", lat, 2);
`endif
        chk("lh_0x41_no_write", nwr, 0);
        xact(1'b1, 2'b10, 1'b0, 32'h42, 32'h5555_AAAA, rd, er, lat, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sw_0x42_err", {31'h0, er}, 32'h1);
        chk("sw_0x42_writes", nwr, 0);
        chk("sw_0x42_mem", mem[16], 32'h1234_8765);
`else
        chk("sw_0x42_err", {31'h0, er}, 32'h0);
        chk("sw_0x42_writes", nwr, 1);
        chk("sw_0x42_mem", mem[16], 32'h5555_AAAA);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
